// File: rtl/bsg_comm_link_tx_arb_pkg.sv
// Shared types and helpers for the comm link transmit arbiter and its
// round-robin picker.
package bsg_comm_link_tx_arb_pkg;

  typedef enum logic {
    eIDLE = 1'b0,
    eSEND = 1'b1
  } state_e;

  // Widest flit and length field the extraction helper can handle.
  localparam int max_flit_width_c = 512;
  localparam int max_len_width_c  = 16;

  // Pull the body-flit count out of a header flit; bits above len_width are zeroed.
  function automatic logic [max_len_width_c-1:0] extract_len(
    input logic [max_flit_width_c-1:0] flit,
    input int                          offset,
    input int                          len_width
  );
    logic [max_flit_width_c-1:0] shifted;
    logic [max_len_width_c-1:0]  len;
    shifted = flit >> offset;
    len     = '0;
    for (int i = 0; i < max_len_width_c; i++) begin
      if (i < len_width) begin
        len[i] = shifted[i];
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/bsg_comm_link_rr_pick.sv
// Combinational round-robin select: first set request bit searching upward
// from last_i+1 with wrap-around.
module bsg_comm_link_rr_pick #(
  parameter int num_req_p = 4,
  localparam int idx_w_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [idx_w_lp-1:0]  last_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [idx_w_lp-1:0]  idx_o,
  output logic                 v_o
);

  // One extra bit so last_i + offset cannot overflow before the wrap.
  logic [idx_w_lp:0] cand;
  logic              found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand = {1'b0, last_i} + (idx_w_lp + 1)'(i);
      if (cand >= (idx_w_lp + 1)'(num_req_p)) begin
        cand = cand - (idx_w_lp + 1)'(num_req_p);
      end
      if (!found && req_i[cand[idx_w_lp-1:0]]) begin
        found                          = 1'b1;
        grant_o[cand[idx_w_lp-1:0]]    = 1'b1;
        idx_o                          = cand[idx_w_lp-1:0];
      end
    end
    v_o = found;
  end

endmodule

// File: rtl/bsg_comm_link_tx_arb.sv
// Packet-locked round-robin arbiter feeding the comm link fused transmit port;
// holds off until calibration completes and aborts the packet if it is lost.
module bsg_comm_link_tx_arb
  import bsg_comm_link_tx_arb_pkg::*;
#(
  parameter int num_req_p    = 4,
  parameter int width_p      = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                 core_clk_i,
  input  logic                 async_reset_n_i,
  input  logic                 calib_done_i,
  input  logic [num_req_p-1:0] req_v_i,
  input  logic [width_p-1:0]   req_data_i [num_req_p],
  output logic [num_req_p-1:0] req_yumi_o,
  output logic                 link_v_o,
  output logic [width_p-1:0]   link_data_o,
  input  logic                 link_ready_i,
  output logic [num_req_p-1:0] grant_o,
  output logic                 abort_o
);

  localparam int idx_w_lp = $clog2(num_req_p);

  state_e                 state_reg;
  logic [num_req_p-1:0]   grant_reg;
  logic [idx_w_lp-1:0]    last_reg;
  logic                   hdr_reg;
  logic [len_width_p-1:0] cnt_reg;
  logic                   abort_reg;

  logic [num_req_p-1:0]   pick_grant;
  logic [idx_w_lp-1:0]    pick_idx;
  logic                   pick_v;

  logic                   owner_v;
  logic [width_p-1:0]     owner_data;
  logic [len_width_p-1:0] hdr_len;
  logic                   xfer;

  bsg_comm_link_rr_pick #(
    .num_req_p(num_req_p)
  ) rr_pick (
    .req_i  (req_v_i),
    .last_i (last_reg),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .v_o    (pick_v)
  );

  // While sending, last_reg always holds the owner's index.
  assign owner_v    = req_v_i[last_reg];
  assign owner_data = req_data_i[last_reg];
  assign hdr_len    = len_width_p'(extract_len(max_flit_width_c'(owner_data),
                                               len_offset_p, len_width_p));

  // Calibration gating wins over everything, including the final flit.
  assign link_v_o    = (state_reg == eSEND) && calib_done_i && owner_v;
  assign link_data_o = link_v_o ? owner_data : '0;
  assign xfer        = link_v_o && link_ready_i;

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_yumi
    assign req_yumi_o[gi] = grant_reg[gi] & xfer;
  end

  assign grant_o = grant_reg;
  assign abort_o = abort_reg;

  always_ff @(posedge core_clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_reg <= eIDLE;
      grant_reg <= '0;
      last_reg  <= idx_w_lp'(num_req_p - 1);
      hdr_reg   <= 1'b1;
      cnt_reg   <= '0;
      abort_reg <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        eIDLE: begin
          if (calib_done_i && pick_v) begin
            grant_reg <= pick_grant;
            last_reg  <= pick_idx;
            hdr_reg   <= 1'b1;
            state_reg <= eSEND;
          end
        end
        eSEND: begin
          if (!calib_done_i) begin
            state_reg <= eIDLE;
            grant_reg <= '0;
            cnt_reg   <= '0;
            hdr_reg   <= 1'b1;
            abort_reg <= 1'b1;
          end else if (xfer) begin
            if (hdr_reg) begin
              if (hdr_len == '0) begin
                state_reg <= eIDLE;
                grant_reg <= '0;
              end else begin
                cnt_reg <= hdr_len;
                hdr_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg - len_width_p'(1);
              if (cnt_reg == len_width_p'(1)) begin
                state_reg <= eIDLE;
                grant_reg <= '0;
                hdr_reg   <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= eIDLE;
      endcase
    end
  end

endmodule
